wb_arbiter: RTL and testbench

Write-back arbiter that shares the single register-file write port (GPR/FPR) among three execution-unit result streams: integer ALU, multiplier and FPU. Each unit hands its result over a valid/ready handshake into a one-entry holding slot. The arbiter grants one slot per cycle and drives a registered write port into the decode stage's register files: write enable, destination, data and GPR/FPR select. Write ordering between units to the same destination is guaranteed by the issue-stage scoreboard, not by this block.

---
 rtl/wb_arbiter.sv | 231 +++++++++++++++++++++++
 tb/tb_wb_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// wb_arbiter
//
// Write-back arbiter for the shared register-file write port. Three result
// streams (integer ALU, multiplier, FPU) each hand results over a valid/ready
// handshake into a one-entry holding slot. One occupied slot is granted per
// cycle. The granted entry is registered onto the write port (wb_*) toward
// the GPR/FPR files in decode.
//
// Write ordering between units to the same destination is guaranteed by the
// issue-stage scoreboard. This block does not enforce it.
//
// Compile-time option:
//   WB_RR_EN  defined   -> round-robin grant (ALU -> MUL -> FPU -> ALU)
//             undefined -> fixed priority FPU > MUL > ALU
//
// Ports:
//   clk, rst                   clock, synchronous active-low reset
//   <u>_valid/_ready           per-unit handshake (u = alu, mul, fpu)
//   <u>_rd/_data/_fpr          per-unit destination, value, FPR/GPR target
//   wb_we/wb_reg/wb_data       registered write port
//   wb_fpr_sel                 1 = FPR write, 0 = GPR write
//   wb_pending                 any holding slot occupied
//   cnt_clr                    synchronous clear of conflict_cnt
//   conflict_cnt               saturating count of cycles with >=2 slots full

module wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              alu_fpr,

  input  logic              mul_valid,
  output logic              mul_ready,
  input  logic [ADDR_W-1:0] mul_rd,
  input  logic [DATA_W-1:0] mul_data,
  input  logic              mul_fpr,

  input  logic              fpu_valid,
  output logic              fpu_ready,
  input  logic [ADDR_W-1:0] fpu_rd,
  input  logic [DATA_W-1:0] fpu_data,
  input  logic              fpu_fpr,

  output logic              wb_we,
  output logic [ADDR_W-1:0] wb_reg,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_fpr_sel,
  output logic              wb_pending,

  input  logic              cnt_clr,
  output logic [15:0]       conflict_cnt
);

  localparam int NREQ = 3;
  localparam int ALU  = 0;
  localparam int MUL  = 1;
  localparam int FPU  = 2;

  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_fpr;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   req_load;
  logic [ADDR_W-1:0] req_rd   [NREQ];
  logic [DATA_W-1:0] req_data [NREQ];

  logic [NREQ-1:0]   slot_full;
  logic [NREQ-1:0]   slot_fpr;
  logic [ADDR_W-1:0] slot_rd   [NREQ];
  logic [DATA_W-1:0] slot_data [NREQ];

  logic [NREQ-1:0]   grant;
  logic [1:0]        grant_idx;
  logic              grant_any;
  logic              multi_full;

  assign req_valid = {fpu_valid, mul_valid, alu_valid};
  assign req_fpr   = {fpu_fpr, mul_fpr, alu_fpr};

  assign req_rd[ALU]   = alu_rd;
  assign req_rd[MUL]   = mul_rd;
  assign req_rd[FPU]   = fpu_rd;
  assign req_data[ALU] = alu_data;
  assign req_data[MUL] = mul_data;
  assign req_data[FPU] = fpu_data;

  // A slot frees up in the same cycle it is granted, so a requester can
  // stream one result per cycle while it keeps winning.
  assign req_ready = rst ? (~slot_full | grant) : '0;

  assign alu_ready = req_ready[ALU];
  assign mul_ready = req_ready[MUL];
  assign fpu_ready = req_ready[FPU];

  // Writes to GPR x0 are handshaken normally but never occupy the slot.
  always_comb begin
    req_load = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_load[i] = req_valid[i] & req_ready[i] &
                    (req_fpr[i] | (req_rd[i] != '0));
    end
  end

  // ---------------------------------------------------------------------
  // Grant selection
  // ---------------------------------------------------------------------
`ifdef WB_RR_EN
  // rr_ptr names the requester searched first, i.e. the one after the last
  // grant. It starts at ALU after reset.
  logic [1:0] rr_ptr;

  always_comb begin
    grant = '0;
    case (rr_ptr)
      2'd1: begin
        if (slot_full[MUL])      grant[MUL] = 1'b1;
        else if (slot_full[FPU]) grant[FPU] = 1'b1;
        else if (slot_full[ALU]) grant[ALU] = 1'b1;
      end
      2'd2: begin
        if (slot_full[FPU])      grant[FPU] = 1'b1;
        else if (slot_full[ALU]) grant[ALU] = 1'b1;
        else if (slot_full[MUL]) grant[MUL] = 1'b1;
      end
      default: begin
        if (slot_full[ALU])      grant[ALU] = 1'b1;
        else if (slot_full[MUL]) grant[MUL] = 1'b1;
        else if (slot_full[FPU]) grant[FPU] = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rr_ptr <= 2'd0;
    end else if (grant_any) begin
      rr_ptr <= (grant_idx == 2'd2) ? 2'd0 : grant_idx + 2'd1;
    end
  end
`else
  always_comb begin
    grant = '0;
    if (slot_full[FPU])      grant[FPU] = 1'b1;
    else if (slot_full[MUL]) grant[MUL] = 1'b1;
    else if (slot_full[ALU]) grant[ALU] = 1'b1;
  end
`endif

  always_comb begin
    grant_idx = 2'd0;
    if (grant[MUL]) grant_idx = 2'd1;
    if (grant[FPU]) grant_idx = 2'd2;
  end

  assign grant_any = |grant;

  // ---------------------------------------------------------------------
  // Holding slots
  // ---------------------------------------------------------------------
  // A new entry overrides the clear from a same-cycle grant, so the slot
  // reloads instead of emptying.
  always_ff @(posedge clk) begin
    if (!rst) begin
      slot_full <= '0;
      slot_fpr  <= '0;
      for (int i = 0; i < NREQ; i++) begin
        slot_rd[i]   <= '0;
        slot_data[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (req_load[i]) begin
          slot_full[i] <= 1'b1;
          slot_fpr[i]  <= req_fpr[i];
          slot_rd[i]   <= req_rd[i];
          slot_data[i] <= req_data[i];
        end else if (grant[i]) begin
          slot_full[i] <= 1'b0;
        end
      end
    end
  end

  assign wb_pending = |slot_full;

  // ---------------------------------------------------------------------
  // Registered write port
  // ---------------------------------------------------------------------
  // Destination/data hold their last value when there is no grant.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wb_we      <= 1'b0;
      wb_reg     <= '0;
      wb_data    <= '0;
      wb_fpr_sel <= 1'b0;
    end else begin
      wb_we <= grant_any;
      if (grant_any) begin
        wb_reg     <= slot_rd[grant_idx];
        wb_data    <= slot_data[grant_idx];
        wb_fpr_sel <= slot_fpr[grant_idx];
      end
    end
  end

  // ---------------------------------------------------------------------
  // Conflict counter
  // ---------------------------------------------------------------------
  // Only one slot can be granted per cycle, so two or more full slots means
  // at least one requester is waiting this cycle.
  assign multi_full = (slot_full[ALU] & slot_full[MUL]) |
                      (slot_full[ALU] & slot_full[FPU]) |
                      (slot_full[MUL] & slot_full[FPU]);

  always_ff @(posedge clk) begin
    if (!rst) begin
      conflict_cnt <= '0;
    end else if (cnt_clr) begin
      conflict_cnt <= '0;
    end else if (multi_full && (conflict_cnt != 16'hFFFF)) begin
      conflict_cnt <= conflict_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          alu_valid = 1'b0, mul_valid = 1'b0, fpu_valid = 1'b0;
  logic          alu_fpr = 1'b0, mul_fpr = 1'b0, fpu_fpr = 1'b0;
  logic [AW-1:0] alu_rd = '0, mul_rd = '0, fpu_rd = '0;
  logic [DW-1:0] alu_data = '0, mul_data = '0, fpu_data = '0;
  logic          cnt_clr = 1'b0;
  logic          alu_ready, mul_ready, fpu_ready;
  logic          wb_we, wb_fpr_sel, wb_pending;
  logic [AW-1:0] wb_reg;
  logic [DW-1:0] wb_data;
  logic [15:0]   conflict_cnt;

  wb_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd),
    .alu_data(alu_data), .alu_fpr(alu_fpr),
    .mul_valid(mul_valid), .mul_ready(mul_ready), .mul_rd(mul_rd),
    .mul_data(mul_data), .mul_fpr(mul_fpr),
    .fpu_valid(fpu_valid), .fpu_ready(fpu_ready), .fpu_rd(fpu_rd),
    .fpu_data(fpu_data), .fpu_fpr(fpu_fpr),
    .wb_we(wb_we), .wb_reg(wb_reg), .wb_data(wb_data),
    .wb_fpr_sel(wb_fpr_sel), .wb_pending(wb_pending),
    .cnt_clr(cnt_clr), .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Unit index: 0 = ALU, 1 = MUL, 2 = FPU.
  logic [2:0]    in_v, in_f;
  logic [AW-1:0] in_rd [3];
  logic [DW-1:0] in_d  [3];
  assign in_v = {fpu_valid, mul_valid, alu_valid};
  assign in_f = {fpu_fpr, mul_fpr, alu_fpr};
  assign in_rd[0] = alu_rd;   assign in_rd[1] = mul_rd;   assign in_rd[2] = fpu_rd;
  assign in_d[0]  = alu_data; assign in_d[1]  = mul_data; assign in_d[2]  = fpu_data;

  logic [2:0]    m_full = '0;
  logic [2:0]    m_fpr = '0;
  logic [AW-1:0] m_rd [3];
  logic [DW-1:0] m_d  [3];
  logic          m_we = 1'b0, m_wfpr = 1'b0;
  logic [AW-1:0] m_reg = '0;
  logic [DW-1:0] m_wdata = '0;
  int            m_cnt = 0;
  logic          mon_en = 1'b0;
  int            g_m;
  logic [2:0]    m_rdy;
`ifdef WB_RR_EN
  int            m_ptr = 0;
`endif

  // Winner among full slots; later assignments win.
  always_comb begin
    g_m = -1;
`ifdef WB_RR_EN
    for (int k = 2; k >= 0; k--) if (m_full[(m_ptr + k) % 3]) g_m = (m_ptr + k) % 3;
`else
    for (int u = 0; u < 3; u++) if (m_full[u]) g_m = u;
`endif
  end

  always_comb begin
    m_rdy = '0;
    for (int i = 0; i < 3; i++) m_rdy[i] = rst && (!m_full[i] || g_m == i);
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (!rst) begin
      mon_en  <= 1'b1;
      m_full  <= '0;
      m_we    <= 1'b0;
      m_reg   <= '0;
      m_wdata <= '0;
      m_wfpr  <= 1'b0;
      m_cnt   <= 0;
`ifdef WB_RR_EN
      m_ptr   <= 0;
`endif
    end else begin
      m_we <= (g_m >= 0);
      if (g_m >= 0) begin
        m_reg   <= m_rd[g_m[1:0]];
        m_wdata <= m_d[g_m[1:0]];
        m_wfpr  <= m_fpr[g_m[1:0]];
`ifdef WB_RR_EN
        m_ptr   <= (g_m + 1) % 3;
`endif
      end
      if (cnt_clr) m_cnt <= 0;
      else if ($countones(m_full) >= 2 && m_cnt < 65535) m_cnt <= m_cnt + 1;
      for (int i = 0; i < 3; i++) begin
        if (in_v[i] && m_rdy[i] && (in_f[i] || in_rd[i] != '0)) begin
          m_full[i] <= 1'b1;
          m_fpr[i]  <= in_f[i];
          m_rd[i]   <= in_rd[i];
          m_d[i]    <= in_d[i];
        end else if (g_m == i) begin
          m_full[i] <= 1'b0;
        end
      end
    end
  end

  typedef struct {
    logic          fpr;
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
    int            cyc;
  } wr_t;
  wr_t wlog[$];

  // Per-cycle compare against the model, plus a log of observed writes.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("wb_we", wb_we, m_we);
      chk("wb_reg", wb_reg, m_reg);
      chk("wb_data", wb_data, m_wdata);
      chk("wb_fpr_sel", wb_fpr_sel, m_wfpr);
      chk("wb_pending", wb_pending, |m_full);
      chk("conflict_cnt", conflict_cnt, m_cnt);
      chk("alu_ready", alu_ready, m_rdy[0]);
      chk("mul_ready", mul_ready, m_rdy[1]);
      chk("fpu_ready", fpu_ready, m_rdy[2]);
      if (wb_we === 1'b1) wlog.push_back('{wb_fpr_sel, wb_reg, wb_data, cyc});
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic clear_valids();
    alu_valid = 1'b0; mul_valid = 1'b0; fpu_valid = 1'b0;
    alu_fpr = 1'b0;   mul_fpr = 1'b0;   fpu_fpr = 1'b0;
  endtask

  task automatic check_log(input string name, input int k, input logic fpr,
                           input logic [AW-1:0] rd, input logic [DW-1:0] data);
    if (wlog.size() > k) begin
      chk({name, "_fpr"}, wlog[k].fpr, fpr);
      chk({name, "_rd"}, wlog[k].rd, rd);
      chk({name, "_data"}, wlog[k].data, data);
    end else begin
      chk({name, "_present"}, 0, 1);
    end
  endtask

  initial begin
    // Reset with every requester asserting valid.
    rst = 1'b0;
    alu_valid = 1; mul_valid = 1; fpu_valid = 1;
    alu_rd = 5'd1; mul_rd = 5'd2; fpu_rd = 5'd3;
    step(); step();
    @(negedge clk);
    chk("rst_alu_ready", alu_ready, 0);
    chk("rst_mul_ready", mul_ready, 0);
    chk("rst_fpu_ready", fpu_ready, 0);
    chk("rst_wb_we", wb_we, 0);
    chk("rst_cnt", conflict_cnt, 0);
    chk("rst_wb_data", wb_data, 0);
    step();
    rst = 1'b1;
    clear_valids();

    // First write two cycles after valid.
    alu_valid = 1; alu_rd = 5'd3; alu_data = 32'h1234;
    step();
    clear_valids();
    step();
    @(negedge clk);
    chk("first_we", wb_we, 1);
    chk("first_reg", wb_reg, 3);
    chk("first_data", wb_data, 32'h1234);
    chk("first_fpr", wb_fpr_sel, 0);
    step();

    // Three simultaneous results.
    wlog.delete();
    alu_valid = 1; alu_rd = 5'd1; alu_data = 32'hA1;
    mul_valid = 1; mul_rd = 5'd2; mul_data = 32'hB2;
    fpu_valid = 1; fpu_rd = 5'd4; fpu_data = 32'hC4; fpu_fpr = 1;
    step();
    clear_valids();
    idle(5);
    chk("sim_count", wlog.size(), 3);
`ifdef WB_RR_EN
    check_log("sim_w0", 0, 0, 5'd2, 32'hB2);
    check_log("sim_w1", 1, 1, 5'd4, 32'hC4);
`else
    check_log("sim_w0", 0, 1, 5'd4, 32'hC4);
    check_log("sim_w1", 1, 0, 5'd2, 32'hB2);
`endif
    check_log("sim_w2", 2, 0, 5'd1, 32'hA1);
    if (wlog.size() == 3) chk("sim_span", wlog[2].cyc - wlog[0].cyc, 2);
    chk("sim_conflict", conflict_cnt, 2);

    // GPR x0 drop, then FPR f0 write.
    wlog.delete();
    alu_valid = 1; alu_rd = 5'd0; alu_fpr = 0; alu_data = 32'hDEAD;
    @(negedge clk);
    chk("x0_ready", alu_ready, 1);
    step();
    clear_valids();
    @(negedge clk);
    chk("x0_pending", wb_pending, 0);
    idle(3);
    chk("x0_writes", wlog.size(), 0);
    alu_valid = 1; alu_rd = 5'd0; alu_fpr = 1; alu_data = 32'h55;
    step();
    clear_valids();
    idle(3);
    chk("f0_writes", wlog.size(), 1);
    check_log("f0_w", 0, 1, 5'd0, 32'h55);

    // Back-to-back MUL results.
    wlog.delete();
    for (int k = 1; k <= 4; k++) begin
      mul_valid = 1; mul_rd = 5'd6; mul_data = k;
      @(negedge clk);
      chk("b2b_ready", mul_ready, 1);
      step();
    end
    clear_valids();
    idle(3);
    chk("b2b_count", wlog.size(), 4);
    for (int k = 0; k < 4; k++) check_log("b2b_w", k, 0, 5'd6, k + 1);
    if (wlog.size() == 4) chk("b2b_span", wlog[3].cyc - wlog[0].cyc, 3);

    // Reset mid-operation with ALU and FPU slots full.
    wlog.delete();
    alu_valid = 1; alu_rd = 5'd7; alu_data = 32'h77;
    fpu_valid = 1; fpu_rd = 5'd8; fpu_fpr = 1; fpu_data = 32'h88;
    step();
    clear_valids();
    rst = 1'b0;
    @(negedge clk);
    chk("mid_pending_before", wb_pending, 1);
    chk("mid_ready_in_rst", fpu_ready, 0);
    step();
    rst = 1'b1;
    idle(4);
    chk("mid_writes", wlog.size(), 0);
    chk("mid_pending", wb_pending, 0);
    chk("mid_cnt", conflict_cnt, 0);
    chk("mid_we", wb_we, 0);

    // All three streaming for 9 cycles.
    wlog.delete();
    alu_valid = 1; alu_rd = 5'd10; alu_data = 32'h100;
    mul_valid = 1; mul_rd = 5'd11; mul_data = 32'h200;
    fpu_valid = 1; fpu_rd = 5'd12; fpu_data = 32'h300;
    for (int k = 0; k < 9; k++) begin
`ifndef WB_RR_EN
      if (k == 3) begin
        @(negedge clk);
        chk("starve_alu_ready", alu_ready, 0);
      end
`endif
      step();
    end
    clear_valids();
    idle(8);
    for (int k = 0; k < 9; k++) begin
`ifdef WB_RR_EN
      check_log("rr_w", k, 0, 5'd10 + 5'(k % 3), 32'h100 * (k % 3 + 1));
`else
      check_log("fix_w", k, 0, 5'd12, 32'h300);
`endif
    end

    // Counter clear.
    cnt_clr = 1;
    step();
    cnt_clr = 0;
    @(negedge clk);
    chk("cnt_clr", conflict_cnt, 0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected finish before 200000");
    $fatal(1);
  end

endmodule
